alu_unit: RTL and testbench
===========================

Name: alu_unit

Overview:
- Parameterised integer ALU: add, add-with-carry, subtract, increment, decrement, AND, NOT, rotate left and rotate right.
- Status flags: carry_out, borrow, zero, parity, invalid_op.
- Single-cycle combinational datapath with a registered output stage, so results and flags are valid one clock after the inputs are sampled.
- Used as the arithmetic/logic execution unit inside a datapath.

Parameters:
- BUS_WIDTH, 8, width of operands a, b and result y (must be >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and opcode are sampled this cycle
- opcode  input  4  operation select
- a  input  BUS_WIDTH  operand A
- b  input  BUS_WIDTH  operand B
- carry_in  input  1  carry input, used by ADD_CARRY only
- out_valid  output  1  result registers hold a new result this cycle
- y  output  BUS_WIDTH  result
- carry_out  output  1  unsigned carry out of the MSB
- borrow  output  1  unsigned borrow
- zero  output  1  y equals 0
- parity  output  1  XOR of all bits of y (1 means an odd count of ones)
- invalid_op  output  1  opcode is not defined

Behaviour:
- Reset: asserting rst_n low asynchronously clears every output to 0 (y, carry_out, borrow, zero, parity, invalid_op, out_valid). Release is synchronous to clk.
- Latency: 1 cycle. When in_valid=1 at a rising edge, the outputs take the computed values at that edge and out_valid=1.
- When in_valid=0, out_valid goes to 0 and y and all flags hold their previous values.
- No backpressure; a new operation may be issued every cycle.
- Arithmetic is unsigned and computed at BUS_WIDTH+1 bits. y is the low BUS_WIDTH bits.
- Opcodes:
  - 1 ADD: y=a+b; carry_out=bit BUS_WIDTH.
  - 2 ADD_CARRY: y=a+b+carry_in; carry_out=bit BUS_WIDTH.
  - 3 SUB: y=a-b (wraps modulo 2^BUS_WIDTH); borrow=(a<b).
  - 4 INC: y=a+1; carry_out=(a==all ones); b and carry_in ignored.
  - 5 DEC: y=a-1; borrow=(a==0); b ignored.
  - 6 AND: y=a&b.
  - 7 NOT: y=~a.
  - 8 ROL: y={a[BUS_WIDTH-2:0],a[BUS_WIDTH-1]}, a rotate by 1 with no carry involvement.
  - 9 ROR: y={a[0],a[BUS_WIDTH-1:1]}.
- Flag rules:
  - carry_out is 0 for every opcode except 1, 2 and 4.
  - borrow is 0 for every opcode except 3 and 5.
  - zero and parity are derived from the final y for all valid opcodes.
- Invalid opcodes (0 and 10–15): y=0, carry_out=0, borrow=0, zero=0, parity=0, invalid_op=1. invalid_op is 0 for opcodes 1–9.
- X/unknown inputs are not required to be handled; no latches may be inferred. The combinational case statement has a default.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode width (4);
  - named opcode constants: OP_ADD=1, OP_ADD_CARRY=2, OP_SUB=3, OP_INC=4, OP_DEC=5, OP_AND=6, OP_NOT=7, OP_ROL=8, OP_ROR=9;
  - an opcode-is-valid function.
- One natural sub-module, alu_core: a purely combinational opcode decode producing y and all flags.
- alu_unit wraps alu_core with the reset-able output register and the valid pipeline bit.

Test Plan (BUS_WIDTH=8; check outputs 1 cycle after in_valid=1):
- Reset: rst_n=0 mid-operation, with no clock edge -> all outputs 0 immediately. Opcode 0 issued -> y=0, invalid_op=1, other flags 0. Opcode 12 gives the same result.
- ADD and ADD_CARRY:
  - op1, a=9, b=33, cin=0 -> y=42, carry_out=0, zero=0, parity=1.
  - op2, same operands, cin=1 -> y=43, parity=0.
  - op1, a=200, b=100 -> y=44, carry_out=1.
- SUB: op3, a=65, b=64 -> y=1, borrow=0, parity=1. op3, a=65, b=66 -> y=255, borrow=1, parity=0. op3, a=b=7 -> y=0, zero=1.
- INC and DEC: op4, a=233, b=69, cin=1 -> y=234, carry_out=0. op4, a=255 -> y=0, carry_out=1, zero=1. op5, a=0, b=3 -> y=255, borrow=1.
- Logic and rotate: op6, a=0x02, b=0x03 -> y=0x02. op7, a=0xFF -> y=0x00, zero=1. op8, a=0x01 -> y=0x02. op8, a=0x80 -> y=0x01. op9, a=0x80 -> y=0x40. op9, a=0x01 -> y=0x80.
- Valid gating: back-to-back ops every cycle give a matching result stream. in_valid=0 for 3 cycles -> out_valid=0 and y holds its last value.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings and helpers shared by the ALU files
package alu_pkg;

    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_ADD       = 4'd1;
    localparam logic [OPCODE_W-1:0] OP_ADD_CARRY = 4'd2;
    localparam logic [OPCODE_W-1:0] OP_SUB       = 4'd3;
    localparam logic [OPCODE_W-1:0] OP_INC       = 4'd4;
    localparam logic [OPCODE_W-1:0] OP_DEC       = 4'd5;
    localparam logic [OPCODE_W-1:0] OP_AND       = 4'd6;
    localparam logic [OPCODE_W-1:0] OP_NOT       = 4'd7;
    localparam logic [OPCODE_W-1:0] OP_ROL       = 4'd8;
    localparam logic [OPCODE_W-1:0] OP_ROR       = 4'd9;

    // Defined opcodes form the contiguous range ADD..ROR
    function automatic logic opcode_is_valid(input logic [OPCODE_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_ROR);
    endfunction

endpackage

// File: rtl/alu_unit_if.sv
// rtl/alu_unit_if.sv - operand/opcode request and result/flag bundle for alu_unit
interface alu_unit_if
    import alu_pkg::*;
#(
    parameter int BUS_WIDTH = 8
) ();

    logic                 in_valid;
    logic [OPCODE_W-1:0]  opcode;
    logic [BUS_WIDTH-1:0] a;
    logic [BUS_WIDTH-1:0] b;
    logic                 carry_in;

    logic                 out_valid;
    logic [BUS_WIDTH-1:0] y;
    logic                 carry_out;
    logic                 borrow;
    logic                 zero;
    logic                 parity;
    logic                 invalid_op;

    modport master (
        output in_valid, opcode, a, b, carry_in,
        input  out_valid, y, carry_out, borrow, zero, parity, invalid_op
    );

    modport slave (
        input  in_valid, opcode, a, b, carry_in,
        output out_valid, y, carry_out, borrow, zero, parity, invalid_op
    );

endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational opcode decode producing result and flags
module alu_core
    import alu_pkg::*;
#(
    parameter int BUS_WIDTH = 8
) (
    input  logic [OPCODE_W-1:0]  i_opcode,
    input  logic [BUS_WIDTH-1:0] i_a,
    input  logic [BUS_WIDTH-1:0] i_b,
    input  logic                 i_carry_in,
    output logic [BUS_WIDTH-1:0] o_y,
    output logic                 o_carry_out,
    output logic                 o_borrow,
    output logic                 o_zero,
    output logic                 o_parity,
    output logic                 o_invalid_op
);

    localparam logic [BUS_WIDTH-1:0] ONE = BUS_WIDTH'(1);

    logic                 w_valid;
    logic [BUS_WIDTH:0]   w_a_ext;
    logic [BUS_WIDTH:0]   w_b_ext;
    logic [BUS_WIDTH:0]   w_cin_ext;
    logic [BUS_WIDTH:0]   w_one_ext;
    logic [BUS_WIDTH-1:0] w_y;
    logic                 w_carry;
    logic                 w_borrow;

    assign w_valid   = opcode_is_valid(i_opcode);
    assign w_a_ext   = {1'b0, i_a};
    assign w_b_ext   = {1'b0, i_b};
    assign w_cin_ext = {{BUS_WIDTH{1'b0}}, i_carry_in};
    assign w_one_ext = {1'b0, ONE};

    always_comb begin
        w_y      = '0;
        w_carry  = 1'b0;
        w_borrow = 1'b0;
        case (i_opcode)
            OP_ADD:       {w_carry, w_y} = w_a_ext + w_b_ext;
            OP_ADD_CARRY: {w_carry, w_y} = w_a_ext + w_b_ext + w_cin_ext;
            OP_SUB: begin
                w_y      = i_a - i_b;
                w_borrow = (i_a < i_b);
            end
            OP_INC:       {w_carry, w_y} = w_a_ext + w_one_ext;
            OP_DEC: begin
                w_y      = i_a - ONE;
                w_borrow = (i_a == '0);
            end
            OP_AND:       w_y = i_a & i_b;
            OP_NOT:       w_y = ~i_a;
            OP_ROL:       w_y = {i_a[BUS_WIDTH-2:0], i_a[BUS_WIDTH-1]};
            OP_ROR:       w_y = {i_a[0], i_a[BUS_WIDTH-1:1]};
            default:      w_y = '0;
        endcase
    end

    // Invalid opcodes report a zero result but must not raise the zero flag
    assign o_y          = w_y;
    assign o_carry_out  = w_carry;
    assign o_borrow     = w_borrow;
    assign o_zero       = w_valid && (w_y == '0);
    assign o_parity     = w_valid && (^w_y);
    assign o_invalid_op = !w_valid;

endmodule

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - ALU with one-cycle registered result, flags and valid bit
module alu_unit
    import alu_pkg::*;
#(
    parameter int BUS_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_unit_if.slave  bus
);

    logic [BUS_WIDTH-1:0] w_y;
    logic                 w_carry_out;
    logic                 w_borrow;
    logic                 w_zero;
    logic                 w_parity;
    logic                 w_invalid_op;

    logic                 r_out_valid;
    logic [BUS_WIDTH-1:0] r_y;
    logic                 r_carry_out;
    logic                 r_borrow;
    logic                 r_zero;
    logic                 r_parity;
    logic                 r_invalid_op;

    alu_core #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_core (
        .i_opcode     (bus.opcode),
        .i_a          (bus.a),
        .i_b          (bus.b),
        .i_carry_in   (bus.carry_in),
        .o_y          (w_y),
        .o_carry_out  (w_carry_out),
        .o_borrow     (w_borrow),
        .o_zero       (w_zero),
        .o_parity     (w_parity),
        .o_invalid_op (w_invalid_op)
    );

    // Result and flags hold across idle cycles; only the valid bit drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_y          <= '0;
            r_carry_out  <= 1'b0;
            r_borrow     <= 1'b0;
            r_zero       <= 1'b0;
            r_parity     <= 1'b0;
            r_invalid_op <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_y          <= w_y;
                r_carry_out  <= w_carry_out;
                r_borrow     <= w_borrow;
                r_zero       <= w_zero;
                r_parity     <= w_parity;
                r_invalid_op <= w_invalid_op;
            end
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.y          = r_y;
    assign bus.carry_out  = r_carry_out;
    assign bus.borrow     = r_borrow;
    assign bus.zero       = r_zero;
    assign bus.parity     = r_parity;
    assign bus.invalid_op = r_invalid_op;

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - directed self-checking bench for alu_unit
module tb_alu_unit;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    alu_unit_if #(.BUS_WIDTH(8)) u_if ();

    alu_unit #(
        .BUS_WIDTH (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [7:0] ey,
                             input logic ec, input logic eb, input logic ez,
                             input logic ep, input logic ei);
        check_eq({tag, ".out_valid"},  32'(u_if.out_valid),  32'(ev));
        check_eq({tag, ".y"},          32'(u_if.y),          32'(ey));
        check_eq({tag, ".carry_out"},  32'(u_if.carry_out),  32'(ec));
        check_eq({tag, ".borrow"},     32'(u_if.borrow),     32'(eb));
        check_eq({tag, ".zero"},       32'(u_if.zero),       32'(ez));
        check_eq({tag, ".parity"},     32'(u_if.parity),     32'(ep));
        check_eq({tag, ".invalid_op"}, 32'(u_if.invalid_op), 32'(ei));
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic cin, input logic [7:0] ey,
                          input logic ec, input logic eb, input logic ez,
                          input logic ep, input logic ei);
        @(negedge clk);
        u_if.in_valid = 1'b1;
        u_if.opcode   = op;
        u_if.a        = a;
        u_if.b        = b;
        u_if.carry_in = cin;
        @(posedge clk);
        #1;
        check_out(tag, 1'b1, ey, ec, eb, ez, ep, ei);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        u_if.in_valid = 1'b0;
        u_if.opcode   = 4'd0;
        u_if.a        = 8'd0;
        u_if.b        = 8'd0;
        u_if.carry_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        //      tag        op     a       b       cin   y       c     bo    z     p     inv
        run_op("op0",     4'd0,  8'd5,   8'd6,   1'b1, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("op12",    4'd12, 8'd255, 8'd1,   1'b1, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("add",     4'd1,  8'd9,   8'd33,  1'b0, 8'd42,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("addc",    4'd2,  8'd9,   8'd33,  1'b1, 8'd43,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("add_ovf", 4'd1,  8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("sub",     4'd3,  8'd65,  8'd64,  1'b0, 8'd1,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("sub_neg", 4'd3,  8'd65,  8'd66,  1'b0, 8'd255, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("sub_eq",  4'd3,  8'd7,   8'd7,   1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("inc",     4'd4,  8'd233, 8'd69,  1'b1, 8'd234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("inc_ovf", 4'd4,  8'd255, 8'd0,   1'b0, 8'd0,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("dec_unf", 4'd5,  8'd0,   8'd3,   1'b0, 8'd255, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("and",     4'd6,  8'h02,  8'h03,  1'b0, 8'h02,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("not",     4'd7,  8'hFF,  8'h00,  1'b0, 8'h00,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("rol",     4'd8,  8'h01,  8'h00,  1'b0, 8'h02,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("rol_wrap",4'd8,  8'h80,  8'h00,  1'b0, 8'h01,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("ror",     4'd9,  8'h80,  8'h00,  1'b0, 8'h40,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("ror_wrap",4'd9,  8'h01,  8'h00,  1'b0, 8'h80,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Idle cycles: valid drops, last result (ROR -> 0x80) is held
        @(negedge clk);
        u_if.in_valid = 1'b0;
        u_if.opcode   = 4'd1;
        u_if.a        = 8'd1;
        u_if.b        = 8'd1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_out($sformatf("hold%0d", i), 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Asynchronous reset between clock edges while an operation is in flight
        run_op("pre_rst", 4'd1, 8'd200, 8'd100, 1'b0, 8'd44, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        u_if.in_valid = 1'b0;
        rst_n         = 1'b1;
        run_op("post_rst", 4'd3, 8'd65, 8'd66, 1'b0, 8'd255, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        u_if.in_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
